approx_mult_error_monitor: RTL and testbench

- Downstream stage for the unsigned 8x8 approximate multipliers; consumes each (x, y, z) sample from the multiplier under test.
- Recomputes the exact product internally and accumulates error statistics over a programmed number of samples: error count, sum of error distance, signed error sum, and maximum error with its operands.
- Used in simulation and FPGA characterisation of each multiplier variant; one instance per multiplier under test.

---
 rtl/approx_mult_error_monitor.sv | 128 ++++++++++++
 tb/tb_approx_mult_error_monitor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_error_monitor.sv
// Error-statistics monitor for an unsigned WxW approximate multiplier under test.
// Recomputes x*y exactly and accumulates count, |error| sum, signed error sum and worst case.
module approx_mult_error_monitor #(
   parameter int W     = 8,
   parameter int CNT_W = 16,
   parameter int SUM_W = 2*W + CNT_W
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [CNT_W-1:0]        num_samples,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [W-1:0]            x,
   input  logic [W-1:0]            y,
   input  logic [2*W-1:0]          z,
   output logic                    busy,
   output logic                    done,
   output logic [CNT_W-1:0]        sample_cnt,
   output logic [CNT_W-1:0]        err_cnt,
   output logic [SUM_W-1:0]        sum_ed,
   output logic signed [SUM_W:0]   sum_err,
   output logic [2*W-1:0]          max_ed,
   output logic [W-1:0]            max_x,
   output logic [W-1:0]            max_y
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t             state, state_next;
   logic [CNT_W-1:0]   n_target, acc_cnt, acc_cnt_next;
   logic               accept, clear;

   logic               v1;
   logic [W-1:0]       x1, y1;
   logic [2*W-1:0]     z1;

   logic [2*W-1:0]     exact;
   logic signed [2*W:0] d, neg_d;
   logic [2*W-1:0]     ed;

   // in_ready comes purely from registered state, so no path from in_valid.
   assign in_ready     = (state == RUN) && (acc_cnt < n_target);
   assign accept       = in_valid && in_ready;
   assign clear        = start && ((state == IDLE) || (state == DONE));
   assign acc_cnt_next = acc_cnt + {{(CNT_W-1){1'b0}}, accept};

   assign busy = (state == RUN) || (state == DRAIN);
   assign done = (state == DONE);

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (acc_cnt_next == n_target) state_next = DRAIN;
         DRAIN:   if (!v1) state_next = DONE;
         DONE:    if (start) state_next = RUN;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         n_target <= '0;
         acc_cnt  <= '0;
         v1       <= 1'b0;
      end else begin
         state <= state_next;
         v1    <= accept;
         if (clear) begin
            n_target <= num_samples;
            acc_cnt  <= '0;
         end else if (accept) begin
            acc_cnt  <= acc_cnt_next;
         end
      end
   end

   // NOTE: stage-1 data is qualified by v1, so it needs no reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         x1 <= x;
         y1 <= y;
         z1 <= z;
      end
   end

   // Stage 2: exact product and error at 2W+1 bits signed.
   assign exact = {{W{1'b0}}, x1} * {{W{1'b0}}, y1};
   assign d     = $signed({1'b0, exact}) - $signed({1'b0, z1});
   assign neg_d = -d;
   assign ed    = d[2*W] ? neg_d[2*W-1:0] : d[2*W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sample_cnt <= '0;
         err_cnt    <= '0;
         sum_ed     <= '0;
         sum_err    <= '0;
         max_ed     <= '0;
         max_x      <= '0;
         max_y      <= '0;
      end else if (clear) begin
         sample_cnt <= '0;
         err_cnt    <= '0;
         sum_ed     <= '0;
         sum_err    <= '0;
         max_ed     <= '0;
         max_x      <= '0;
         max_y      <= '0;
      end else if (v1) begin
         sample_cnt <= sample_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         err_cnt    <= err_cnt + {{(CNT_W-1){1'b0}}, (d != '0)};
         sum_ed     <= sum_ed + {{(SUM_W-2*W){1'b0}}, ed};
         sum_err    <= sum_err + {{(SUM_W-2*W){d[2*W]}}, d};
         // Strictly greater keeps the first occurrence on ties.
         if (ed > max_ed) begin
            max_ed <= ed;
            max_x  <= x1;
            max_y  <= y1;
         end
      end
   end

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Directed bench for approx_mult_error_monitor: a reference model pushes expected
// running statistics per accepted sample; they are popped when the DUT reflects them.
module tb_approx_mult_error_monitor;

   localparam int W     = 8;
   localparam int CNT_W = 16;
   localparam int SUM_W = 2*W + CNT_W;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [CNT_W-1:0]      num_samples;
   logic                  in_valid;
   logic                  in_ready;
   logic [W-1:0]          x, y;
   logic [2*W-1:0]        z;
   logic                  busy, done;
   logic [CNT_W-1:0]      sample_cnt, err_cnt;
   logic [SUM_W-1:0]      sum_ed;
   logic signed [SUM_W:0] sum_err;
   logic [2*W-1:0]        max_ed;
   logic [W-1:0]          max_x, max_y;

   approx_mult_error_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
      .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
      .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z(z),
      .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
      .sum_ed(sum_ed), .sum_err(sum_err), .max_ed(max_ed), .max_x(max_x), .max_y(max_y)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     due;
      longint cnt, err, sed, serr, med, mx, my;
   } exp_t;

   exp_t   sb[$];
   int     cyc = 0;
   int     checks = 0;
   int     errors = 0;
   longint m_cnt, m_err, m_sed, m_serr, m_med, m_mx, m_my;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic model_clear();
      m_cnt = 0; m_err = 0; m_sed = 0; m_serr = 0; m_med = 0; m_mx = 0; m_my = 0;
   endtask

   // Advance one clock and compare any scoreboard entries that are now due.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         check("sb_sample_cnt", sample_cnt, e.cnt);
         check("sb_err_cnt",    err_cnt,    e.err);
         check("sb_sum_ed",     sum_ed,     e.sed);
         check("sb_sum_err",    sum_err,    e.serr);
         check("sb_max_ed",     max_ed,     e.med);
         check("sb_max_x",      max_x,      e.mx);
         check("sb_max_y",      max_y,      e.my);
      end
   endtask

   // Drive one cycle of input; a sample is accepted iff valid while in_ready is high.
   task automatic drive(input int xv, input int yv, input int zv, input bit v);
      longint ex, dd, ad;
      exp_t   e;
      x = xv[W-1:0]; y = yv[W-1:0]; z = zv[2*W-1:0]; in_valid = v;
      if (v && in_ready) begin
         ex = longint'(xv) * longint'(yv);
         dd = ex - longint'(zv);
         ad = (dd < 0) ? -dd : dd;
         m_cnt++;
         if (dd != 0) m_err++;
         m_sed  += ad;
         m_serr += dd;
         if (ad > m_med) begin m_med = ad; m_mx = xv; m_my = yv; end
         e = '{due: cyc + 2, cnt: m_cnt, err: m_err, sed: m_sed, serr: m_serr,
               med: m_med, mx: m_mx, my: m_my};
         sb.push_back(e);
      end
      tick();
   endtask

   task automatic start_run(input int n, input string tag);
      start = 1'b1;
      num_samples = n[CNT_W-1:0];
      model_clear();
      tick();
      start = 1'b0;
      check({tag, "_busy"}, busy, 1);
      check({tag, "_done"}, done, 0);
   endtask

   task automatic wait_done(input int budget, input string tag);
      int n = 0;
      while (!done && n < budget) begin
         tick();
         n++;
      end
      check(tag, done, 1);
   endtask

   task automatic check_final(input string tag);
      check({tag, "_busy"},   busy,       0);
      check({tag, "_cnt"},    sample_cnt, m_cnt);
      check({tag, "_err"},    err_cnt,    m_err);
      check({tag, "_sum_ed"}, sum_ed,     m_sed);
      check({tag, "_sum_err"},sum_err,    m_serr);
      check({tag, "_max_ed"}, max_ed,     m_med);
      check({tag, "_max_x"},  max_x,      m_mx);
      check({tag, "_max_y"},  max_y,      m_my);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_samples = '0; in_valid = 1'b0;
      x = '0; y = '0; z = '0;
      model_clear();
      tick();
      tick();
      check("rst_in_ready", in_ready, 0);
      check("rst_busy",     busy,     0);
      check("rst_done",     done,     0);
      check("rst_cnt",      sample_cnt, 0);
      check("rst_sum_err",  sum_err,  0);
      rst = 1'b0;
      tick();

      // Exact products: no error recorded.
      start_run(4, "exact_start");
      drive(3, 5, 15, 1);
      drive(255, 255, 65025, 1);
      drive(0, 7, 0, 1);
      drive(16, 16, 256, 1);
      in_valid = 1'b0;
      wait_done(6, "exact_done");
      check_final("exact");
      check("exact_cnt_lit", sample_cnt, 4);

      // Mixed-sign errors.
      start_run(3, "err_start");
      drive(10, 10, 95, 1);
      drive(20, 20, 410, 1);
      drive(1, 1, 1, 1);
      in_valid = 1'b0;
      wait_done(6, "err_done");
      check_final("err");
      check("err_cnt_lit",    err_cnt, 2);
      check("err_sum_ed_lit", sum_ed,  15);
      check("err_sum_err_lit",sum_err, -5);
      check("err_max_lit",    max_ed,  10);
      check("err_max_x_lit",  max_x,   20);

      // Backpressure: valid held for 5 cycles, only 2 accepted.
      start_run(2, "bp_start");
      for (int i = 0; i < 5; i++) begin
         if (i == 2) check("bp_in_ready_low", in_ready, 0);
         check("bp_done_timing", done, (i >= 4));
         drive(2, 2, 3, 1);
      end
      in_valid = 1'b0;
      check_final("bp");
      check("bp_sum_ed_lit", sum_ed, 2);

      // Zero samples with in_valid high.
      in_valid = 1'b1; x = 8'd9; y = 8'd9; z = 16'd1;
      start_run(0, "zero_start");
      check("zero_in_ready", in_ready, 0);
      wait_done(2, "zero_done");
      in_valid = 1'b0;
      check_final("zero");

      // Tie on max error keeps the first sample.
      start_run(2, "tie_start");
      drive(4, 4, 13, 1);
      drive(3, 4, 9, 1);
      in_valid = 1'b0;
      wait_done(6, "tie_done");
      check_final("tie");
      check("tie_max_x_lit", max_x, 4);
      check("tie_max_y_lit", max_y, 4);

      // Restart from DONE clears statistics on the start edge.
      start_run(5, "restart");
      check("restart_cnt",    sample_cnt, 0);
      check("restart_sum_ed", sum_ed,     0);
      check("restart_max_x",  max_x,      0);

      // Async reset after 2 of 5 samples, between clock edges.
      drive(7, 7, 50, 1);
      drive(9, 9, 81, 1);
      drive(0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_cnt",      sample_cnt, 0);
      check("arst_sum_err",  sum_err,    0);
      check("arst_busy",     busy,       0);
      check("arst_in_ready", in_ready,   0);
      sb.delete();
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      drive(5, 5, 1, 1);
      drive(6, 6, 1, 1);
      in_valid = 1'b0;
      tick();
      check("post_rst_cnt",  sample_cnt, 0);
      check("post_rst_busy", busy,       0);
      check("post_rst_done", done,       0);
      check("sb_empty",      sb.size(),  0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
